// File: rtl/qspi_mem_responder.sv
// qspi_mem_responder: QPI serial memory target, oversampled in clk_i, serving a byte-wide memory port
module qspi_mem_responder #(
   parameter int ADDR_W = 16,
   parameter int DUMMY_CYC = 6,
   parameter logic [7:0] CMD_RD = 8'hEB,
   parameter logic [7:0] CMD_WR = 8'h38
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cs_in,
   input  logic              sck_i,
   input  logic [3:0]        sdio_i,
   output logic [3:0]        sdio_o,
   output logic              sdio_oe_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   input  logic [7:0]        mem_rdata_i
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;
   state_t state, state_n;
   logic [2:0] cs_s, sck_s;
   logic [3:0] sd_s0, sd_s1;
   logic rise, fall, cs_fall, cs_rise;
   logic [7:0] cnt, cnt_n, sh, sh_n, pre, pre_n;
   logic [ADDR_W-5:0] sr, sr_n;
   logic [ADDR_W-1:0] wrd, addr, addr_n, maddr_n;
   logic is_wr, is_wr_n, rd_pend, rd_pend_n, oe_n, req_n, we_n;
   logic [3:0] sdo_n;
   logic [7:0] wdata_n;
   assign wrd = {sr, sd_s1};
   // Edge detects are registered, so the FSM acts 3 cycles after the pin edge
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cs_s <= '0;
         sck_s <= '0;
         sd_s0 <= '0;
         sd_s1 <= '0;
         rise <= 1'b0;
         fall <= 1'b0;
         cs_fall <= 1'b0;
         cs_rise <= 1'b0;
      end else begin
         cs_s <= {cs_s[1:0], cs_in};
         sck_s <= {sck_s[1:0], sck_i};
         sd_s0 <= sdio_i;
         sd_s1 <= sd_s0;
         rise <= sck_s[1] & ~sck_s[2];
         fall <= ~sck_s[1] & sck_s[2];
         cs_fall <= cs_s[2] & ~cs_s[1];
         cs_rise <= ~cs_s[2] & cs_s[1];
      end
   end
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      sr_n = sr;
      is_wr_n = is_wr;
      addr_n = addr;
      sh_n = sh;
      pre_n = rd_pend ? mem_rdata_i : pre;
      rd_pend_n = mem_req_o & ~mem_we_o;
      sdo_n = sdio_o;
      oe_n = sdio_oe_o;
      req_n = 1'b0;
      we_n = mem_we_o;
      maddr_n = mem_addr_o;
      wdata_n = mem_wdata_o;
      case (state)
         IDLE: begin
            oe_n = 1'b0;
            if (cs_fall) begin
               state_n = CMD;
               cnt_n = '0;
            end
         end
         CMD: if (rise) begin
            sr_n = wrd[ADDR_W-5:0];
            cnt_n = cnt + 8'd1;
            if (cnt[0]) begin
               cnt_n = '0;
               is_wr_n = wrd[7:0] == CMD_WR;
               state_n = (wrd[7:0] == CMD_RD || wrd[7:0] == CMD_WR) ? ADDR : IGNORE;
            end
         end
         ADDR: if (rise) begin
            sr_n = wrd[ADDR_W-5:0];
            cnt_n = cnt + 8'd1;
            if (cnt == 8'd5) begin
               cnt_n = '0;
               addr_n = wrd;
               state_n = is_wr ? WDATA : DUMMY;
               req_n = ~is_wr;
               we_n = is_wr ? mem_we_o : 1'b0;
               maddr_n = is_wr ? mem_addr_o : wrd;
            end
         end
         DUMMY: if (rise) begin
            cnt_n = cnt + 8'd1;
            if (cnt == 8'(DUMMY_CYC - 1)) begin
               cnt_n = '0;
               sh_n = pre;
               state_n = RDATA;
            end
         end
         // High nibble launches the prefetch of the next byte; low nibble swaps it in
         RDATA: if (fall) begin
            oe_n = 1'b1;
            cnt_n = cnt ^ 8'd1;
            if (!cnt[0]) begin
               sdo_n = sh[7:4];
               req_n = 1'b1;
               we_n = 1'b0;
               addr_n = addr + ADDR_W'(1);
               maddr_n = addr + ADDR_W'(1);
            end else begin
               sdo_n = sh[3:0];
               sh_n = pre;
            end
         end
         WDATA: if (rise) begin
            sr_n = wrd[ADDR_W-5:0];
            cnt_n = cnt ^ 8'd1;
            if (cnt[0]) begin
               req_n = 1'b1;
               we_n = 1'b1;
               maddr_n = addr;
               wdata_n = wrd[7:0];
               addr_n = addr + ADDR_W'(1);
            end
         end
         default: ;
      endcase
      if (cs_rise) begin
         state_n = IDLE;
         oe_n = 1'b0;
         req_n = 1'b0;
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         cnt <= '0;
         sr <= '0;
         is_wr <= 1'b0;
         addr <= '0;
         sh <= '0;
         pre <= '0;
         rd_pend <= 1'b0;
         sdio_o <= '0;
         sdio_oe_o <= 1'b0;
         mem_req_o <= 1'b0;
         mem_we_o <= 1'b0;
         mem_addr_o <= '0;
         mem_wdata_o <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         sr <= sr_n;
         is_wr <= is_wr_n;
         addr <= addr_n;
         sh <= sh_n;
         pre <= pre_n;
         rd_pend <= rd_pend_n;
         sdio_o <= sdo_n;
         sdio_oe_o <= oe_n;
         mem_req_o <= req_n;
         mem_we_o <= we_n;
         mem_addr_o <= maddr_n;
         mem_wdata_o <= wdata_n;
      end
   end
endmodule

// File: tb/tb_qspi_mem_responder.sv
// tb_qspi_mem_responder: random and directed QPI transactions against a queue-based scoreboard
module tb_qspi_mem_responder;
   localparam int H = 8;
   typedef struct packed {logic we; logic [15:0] a; logic [7:0] d;} req_t;
   logic clk = 0, rst = 1, cs_n = 1, sck = 0;
   logic [3:0] sdi = '0, sdo;
   logic oe, req, we;
   logic [15:0] addr;
   logic [7:0] wdata, rdata;
   logic [7:0] mem [0:65535];
   logic [7:0] rm [0:65535];
   logic loaded = 0;
   logic rd_active = 0, oe_ok = 0;
   req_t rq[$];
   logic [3:0] nq[$];
   req_t e, g;
   logic [3:0] en;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   qspi_mem_responder dut (
      .clk_i(clk), .rst_i(rst), .cs_in(cs_n), .sck_i(sck), .sdio_i(sdi),
      .sdio_o(sdo), .sdio_oe_o(oe), .mem_req_o(req), .mem_we_o(we),
      .mem_addr_o(addr), .mem_wdata_o(wdata), .mem_rdata_i(rdata)
   );
   function automatic logic [7:0] init_val(input int i);
      case (i)
         16'h0010: return 8'hA5;
         16'h0011: return 8'h3C;
         16'h0012: return 8'h00;
         16'h0013: return 8'hFF;
         default: return 8'(i * 37 + (i >> 8) * 11 + 3);
      endcase
   endfunction
   // Memory behind the responder: read data valid one cycle after the request
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
         loaded <= 1;
      end else if (req && we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
   always @(negedge clk) begin
      if (req) begin
         checks++;
         g = '{we, addr, we ? wdata : 8'h00};
         if (rq.size() == 0) begin
            errors++;
            $display("FAIL mem_req_unexpected: got we=%0d addr=%h data=%h, required no request", we, addr, wdata);
         end else begin
            e = rq.pop_front();
            if (g !== e) begin
               errors++;
               $display("FAIL mem_req: got we=%0d addr=%h data=%h, required we=%0d addr=%h data=%h", g.we, g.a, g.d, e.we, e.a, e.d);
            end
         end
      end
      if (!oe_ok) begin
         checks++;
         if (oe !== 1'b0) begin
            errors++;
            $display("FAIL oe_idle: got sdio_oe_o=%b, required 0", oe);
         end
      end
   end
   always @(posedge sck) if (rd_active) begin
      checks++;
      if (nq.size() == 0) begin
         errors++;
         $display("FAIL rd_nibble_unexpected: got sdio_o=%h, required no nibble", sdo);
      end else begin
         en = nq.pop_front();
         if (sdo !== en || oe !== 1'b1) begin
            errors++;
            $display("FAIL rd_nibble: got sdio_o=%h oe=%b, required %h oe=1", sdo, oe, en);
         end
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
   end
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic clock_nib(input logic [3:0] v, input bit last);
      sdi = v;
      tick(H);
      sck = 1;
      tick(H);
      if (!last) sck = 0;
   endtask
   task automatic start_tx();
      cs_n = 0;
      tick(H);
   endtask
   task automatic end_tx();
      tick(H);
      cs_n = 1;
      rd_active = 0;
      tick(4);
      oe_ok = 0;
      tick(H);
      sck = 0;
      tick(2 * H);
   endtask
   task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
      clock_nib(op[7:4], 0);
      clock_nib(op[3:0], 0);
      for (int i = 5; i >= 0; i--) clock_nib(a[i*4 +: 4], 0);
   endtask
   task automatic chk_reset();
      checks++;
      if ({sdo, oe, req, we, addr, wdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, required 0", {sdo, oe, req, we, addr, wdata});
      end
   endtask
   task automatic do_read(input logic [23:0] a, input int k);
      logic [15:0] b;
      logic [7:0] d;
      rq.push_back('{1'b0, a[15:0], 8'h00});
      for (int j = 1; j <= (k + 1) / 2; j++) rq.push_back('{1'b0, a[15:0] + 16'(j), 8'h00});
      for (int i = 0; i < k; i++) begin
         b = a[15:0] + 16'(i / 2);
         d = rm[b];
         nq.push_back(i % 2 ? d[3:0] : d[7:4]);
      end
      start_tx();
      send_hdr(8'hEB, a);
      repeat (6) clock_nib(4'h0, 0);
      oe_ok = 1;
      rd_active = 1;
      for (int i = 0; i < k; i++) clock_nib(4'($urandom), i == k - 1);
      end_tx();
   endtask
   task automatic do_write(input logic [23:0] a, input logic [3:0] nib [16], input int n);
      logic [15:0] b;
      for (int j = 0; j < n / 2; j++) begin
         b = a[15:0] + 16'(j);
         rq.push_back('{1'b1, b, {nib[2*j], nib[2*j+1]}});
         rm[b] = {nib[2*j], nib[2*j+1]};
      end
      start_tx();
      send_hdr(8'h38, a);
      for (int i = 0; i < n; i++) clock_nib(nib[i], i == n - 1);
      end_tx();
   endtask
   logic [3:0] nb [16];
   int n;
   initial begin
      for (int i = 0; i < 65536; i++) rm[i] = init_val(i);
      tick(2);
      chk_reset();
      rst = 0;
      tick(4);
      do_read(24'h000010, 8);
      nb[0] = 4'h1; nb[1] = 4'h2; nb[2] = 4'h3; nb[3] = 4'h4; nb[4] = 4'h5;
      do_write(24'h000100, nb, 5);
      nb[0] = 4'hA; nb[1] = 4'hA; nb[2] = 4'hB; nb[3] = 4'hB;
      do_write(24'h00FFFF, nb, 4);
      do_read(24'h00FFFF, 4);
      start_tx();
      clock_nib(4'h9, 0);
      clock_nib(4'hF, 0);
      for (int i = 0; i < 10; i++) clock_nib(4'($urandom), i == 9);
      end_tx();
      do_read(24'h000010, 4);
      do_read(24'h000010, 3);
      start_tx();
      clock_nib(4'hE, 0);
      clock_nib(4'hB, 0);
      clock_nib(4'h0, 0);
      clock_nib(4'h0, 0);
      rst = 1;
      tick(2);
      chk_reset();
      rst = 0;
      for (int i = 0; i < 12; i++) clock_nib(4'h1, i == 11);
      end_tx();
      do_read(24'h000100, 4);
      repeat (14) begin
         if ($urandom_range(0, 1) == 0) do_read(24'($urandom), $urandom_range(1, 10));
         else begin
            n = $urandom_range(1, 9);
            for (int i = 0; i < 16; i++) nb[i] = 4'($urandom);
            do_write(24'($urandom), nb, n);
         end
      end
      tick(10);
      checks++;
      if (rq.size() != 0 || nq.size() != 0) begin
         errors++;
         $display("FAIL leftover: got %0d requests and %0d nibbles pending, required 0", rq.size(), nq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
